// File: rtl/mpadder_pkg.sv
// Shared types and sizing for the mpadder sharing logic.
package mpadder_pkg;

    localparam int unsigned OP_W        = 1027;
    localparam int unsigned RES_W       = OP_W + 1;
    localparam int unsigned TIMEOUT_DFL = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wide enough to hold the timeout value itself.
    function automatic int unsigned wd_cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int unsigned WD_CNT_W_DFL = wd_cnt_width(TIMEOUT_DFL);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NREQ  = 3,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[IDX_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    assign any   = |req;
    assign grant = any ? (NREQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/mpadder_arbiter.sv
// Round-robin scheduler sharing one mpadder among NREQ clients, with a watchdog
// so a hung adder still produces an (errored) ack.
module mpadder_arbiter
    import mpadder_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned W       = OP_W,
    parameter int unsigned TIMEOUT = TIMEOUT_DFL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   ack,
    output logic [W:0]        result,
    output logic              err,
    output logic              busy,
    output logic              add_start,
    output logic              add_subtract,
    output logic [W-1:0]      add_in_a,
    output logic [W-1:0]      add_in_b,
    input  logic [W:0]        add_result,
    input  logic              add_done
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = wd_cnt_width(TIMEOUT);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] wd_cnt;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any;

    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic             sel_sub;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // One-hot AND-OR mux of the winner's operands.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a   = sel_a | req_a[i*W +: W];
                sel_b   = sel_b | req_b[i*W +: W];
                sel_sub = sel_sub | req_sub[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            win_idx      <= '0;
            wd_cnt       <= '0;
            ack          <= '0;
            result       <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            add_start    <= 1'b0;
            add_subtract <= 1'b0;
            add_in_a     <= '0;
            add_in_b     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        win_idx      <= grant_idx;
                        add_in_a     <= sel_a;
                        add_in_b     <= sel_b;
                        add_subtract <= sel_sub;
                        add_start    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_start <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (add_done) begin
                        result <= add_result;
                        err    <= 1'b0;
                        ack    <= NREQ'(1) << win_idx;
                        state  <= RESP;
                    end else if (wd_cnt == CNT_W'(TIMEOUT)) begin
                        result <= '0;
                        err    <= 1'b1;
                        ack    <= NREQ'(1) << win_idx;
                        state  <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    ack    <= '0;
                    err    <= 1'b0;
                    busy   <= 1'b0;
                    rr_ptr <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Self-checking bench for mpadder_arbiter with a 2-cycle adder stub and a
// round-robin reference model.
module tb_mpadder_arbiter;
    import mpadder_pkg::*;

    localparam int NREQ = 3;
    localparam int W    = OP_W;
    localparam int TO   = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   ack;
    logic [W:0]        result;
    logic              err;
    logic              busy;
    logic              add_start;
    logic              add_subtract;
    logic [W-1:0]      add_in_a;
    logic [W-1:0]      add_in_b;
    logic [W:0]        add_result = '0;
    logic              add_done;

    logic [W-1:0]      op_a [NREQ];
    logic [W-1:0]      op_b [NREQ];

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    // Adder stub: done two cycles after start; hang suppresses done entirely.
    logic [1:0] pipe = '0;
    logic       hang = 1'b0;
    always @(posedge clk) begin
        pipe <= {pipe[0], add_start & ~hang};
        if (pipe[0])
            add_result <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                       : ({1'b0, add_in_a} + {1'b0, add_in_b});
    end
    assign add_done = pipe[1];

    mpadder_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_sub      (req_sub),
        .req_a        (req_a),
        .req_b        (req_b),
        .ack          (ack),
        .result       (result),
        .err          (err),
        .busy         (busy),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    // ---------------- reference model ----------------
    function automatic int exp_winner(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [W:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W:0] ea;
        logic [W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return s ? (ea - eb) : (ea + eb);
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 33; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until an ack or the budget expires; gathers observations only.
    task automatic wait_ack(input int budget, input int drop_at, output int cyc,
                            output logic [NREQ-1:0] ack_o, output logic [W:0] res_o,
                            output logic err_o, output int starts, output int busy_cyc,
                            output bit stable);
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        bit started;
        started  = 0;
        sa       = '0;
        sb       = '0;
        cyc      = 0;
        ack_o    = '0;
        res_o    = '0;
        err_o    = 1'b0;
        starts   = 0;
        busy_cyc = 0;
        stable   = 1;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (cyc == drop_at) req_valid = '0;
            if (busy) busy_cyc++;
            if (started && (add_in_a !== sa || add_in_b !== sb)) stable = 0;
            if (add_start) begin
                starts++;
                sa      = add_in_a;
                sb      = add_in_b;
                started = 1;
            end
            if (ack !== '0) begin
                ack_o = ack;
                res_o = result;
                err_o = err;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_sub   = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        tick();
        tick();
        checks++;
        if ({ack, err, busy, add_start, add_subtract} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack=%b err=%b busy=%b start=%b sub=%b, want all 0",
                     ack, err, busy, add_start, add_subtract);
        end
        checks++;
        if (result !== '0 || add_in_a !== '0 || add_in_b !== '0) begin
            errors++;
            $display("FAIL reset_data: result/add_in_a/add_in_b not zero");
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || add_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b start=%b, want 0 0", busy, add_start);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [3];
        logic [W-1:0] tbv [3];
        logic         ts [3];
        logic [W:0]   tr [3];
        int cyc, starts, busy_cyc, w;
        logic [NREQ-1:0] a_o;
        logic [W:0] r_o;
        logic e_o;
        bit stable;
        ta[0] = W'(5);            tbv[0] = W'(3);            ts[0] = 1'b0;
        tr[0] = (W+1)'(8);
        ta[1] = W'(3);            tbv[1] = W'(5);            ts[1] = 1'b1;
        tr[1] = ~((W+1)'(1));
        ta[2] = W'(1) << (W - 1); tbv[2] = W'(1) << (W - 1); ts[2] = 1'b0;
        tr[2] = (W+1)'(1) << W;
        for (int n = 0; n < 3; n++) begin
            op_a[n]    = ta[n];
            op_b[n]    = tbv[n];
            req_sub[n] = ts[n];
            req_valid  = NREQ'(1) << n;
            w = exp_winner(req_valid, ptr_m);
            wait_ack(40, -1, cyc, a_o, r_o, e_o, starts, busy_cyc, stable);
            req_valid = '0;
            checks++;
            if (cyc !== 4 || a_o !== (NREQ'(1) << w)) begin
                errors++;
                $display("FAIL dir%0d_ack: cycle %0d ack %b, want cycle 4 ack %b",
                         n, cyc, a_o, NREQ'(1) << w);
            end
            checks++;
            if (r_o !== tr[n] || e_o !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_result: got %h err %b, want %h err 0", n, r_o, e_o, tr[n]);
            end
            checks++;
            if (starts !== 1 || busy_cyc !== 4) begin
                errors++;
                $display("FAIL dir%0d_start_busy: starts %0d busy %0d, want 1 and 4",
                         n, starts, busy_cyc);
            end
            ptr_m = (w + 1) % NREQ;
            tick();
            checks++;
            if (ack !== '0 || busy !== 1'b0 || result !== tr[n]) begin
                errors++;
                $display("FAIL dir%0d_after: ack %b busy %b result held=%b", n, ack, busy,
                         result === tr[n]);
            end
        end
    endtask

    task automatic test_round_robin();
        int cyc, starts, busy_cyc, w;
        int order [4];
        logic [NREQ-1:0] a_o;
        logic [W:0] r_o;
        logic e_o;
        bit stable;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i]    = rand_op();
            op_b[i]    = rand_op();
            req_sub[i] = 1'($urandom);
        end
        req_valid = '1;
        for (int n = 0; n < 4; n++) begin
            w = exp_winner(req_valid, ptr_m);
            wait_ack(40, -1, cyc, a_o, r_o, e_o, starts, busy_cyc, stable);
            checks++;
            if (w !== order[n] || a_o !== (NREQ'(1) << w) || cyc !== ((n == 0) ? 4 : 5)) begin
                errors++;
                $display("FAIL rr%0d_grant: ack %b after %0d cycles, want ack %b after %0d",
                         n, a_o, cyc, NREQ'(1) << order[n], (n == 0) ? 4 : 5);
            end
            checks++;
            if (r_o !== exp_res(op_a[w], op_b[w], req_sub[w]) || !stable) begin
                errors++;
                $display("FAIL rr%0d_result: got %h stable %0d, want %h stable 1", n, r_o,
                         stable, exp_res(op_a[w], op_b[w], req_sub[w]));
            end
            ptr_m = (w + 1) % NREQ;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        int cyc, starts, busy_cyc, w, idx;
        logic [NREQ-1:0] a_o;
        logic [W:0] r_o;
        logic e_o;
        bit stable;
        hang = 1'b1;
        idx = $urandom_range(0, NREQ - 1);
        op_a[idx] = rand_op();
        op_b[idx] = rand_op();
        req_valid = NREQ'(1) << idx;
        w = exp_winner(req_valid, ptr_m);
        wait_ack(60, -1, cyc, a_o, r_o, e_o, starts, busy_cyc, stable);
        req_valid = '0;
        hang = 1'b0;
        checks++;
        if (a_o !== (NREQ'(1) << w) || cyc !== TO + 3) begin
            errors++;
            $display("FAIL timeout_ack: ack %b at cycle %0d, want %b at cycle %0d",
                     a_o, cyc, NREQ'(1) << w, TO + 3);
        end
        checks++;
        if (e_o !== 1'b1 || r_o !== '0) begin
            errors++;
            $display("FAIL timeout_err: err %b result zero=%b, want err 1 result 0",
                     e_o, r_o === '0);
        end
        ptr_m = (w + 1) % NREQ;
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: err %b, want 0", err);
        end
        idx = $urandom_range(0, NREQ - 1);
        op_a[idx] = rand_op();
        op_b[idx] = rand_op();
        req_sub[idx] = 1'($urandom);
        req_valid = NREQ'(1) << idx;
        w = exp_winner(req_valid, ptr_m);
        wait_ack(40, -1, cyc, a_o, r_o, e_o, starts, busy_cyc, stable);
        req_valid = '0;
        checks++;
        if (cyc !== 4 || a_o !== (NREQ'(1) << w) || e_o !== 1'b0 ||
            r_o !== exp_res(op_a[w], op_b[w], req_sub[w])) begin
            errors++;
            $display("FAIL timeout_recover: cycle %0d ack %b err %b result %h", cyc, a_o, e_o,
                     r_o);
        end
        ptr_m = (w + 1) % NREQ;
        tick();
    endtask

    task automatic test_random();
        int cyc, starts, busy_cyc, w, drop;
        logic [NREQ-1:0] a_o;
        logic [W:0] r_o;
        logic e_o;
        bit stable;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i]    = rand_op();
                op_b[i]    = rand_op();
                req_sub[i] = 1'($urandom);
            end
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : -1;
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w = exp_winner(req_valid, ptr_m);
            wait_ack(40, drop, cyc, a_o, r_o, e_o, starts, busy_cyc, stable);
            req_valid = '0;
            checks++;
            if (cyc !== 4 || a_o !== (NREQ'(1) << w) || e_o !== 1'b0 || !stable ||
                r_o !== exp_res(op_a[w], op_b[w], req_sub[w])) begin
                errors++;
                $display("FAIL rand%0d: cycle %0d ack %b err %b stable %0d result %h, want ack %b %h",
                         n, cyc, a_o, e_o, stable, r_o, NREQ'(1) << w,
                         exp_res(op_a[w], op_b[w], req_sub[w]));
            end
            ptr_m = (w + 1) % NREQ;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int cyc, starts, busy_cyc, w, idx;
        logic [NREQ-1:0] a_o;
        logic [W:0] r_o;
        logic e_o;
        bit stable;
        bit stray;
        idx = $urandom_range(0, NREQ - 1);
        op_a[idx] = rand_op() | W'(1);
        op_b[idx] = rand_op() | W'(1);
        req_sub[idx] = 1'b1;
        req_valid = NREQ'(1) << idx;
        tick();
        tick();
        reset = 1'b1;
        req_valid = '0;
        tick();
        checks++;
        if ({ack, err, busy, add_start, add_subtract} !== '0 || result !== '0 ||
            add_in_a !== '0 || add_in_b !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ack=%b err=%b busy=%b start=%b sub=%b inA0=%b",
                     ack, err, busy, add_start, add_subtract, add_in_a === '0);
        end
        reset = 1'b0;
        ptr_m = 0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack !== '0 || busy !== 1'b0) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL reset_stale_done: ack or busy seen after reset, want none");
        end
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = rand_op();
            op_b[i] = rand_op();
        end
        req_valid = '1;
        w = exp_winner(req_valid, ptr_m);
        wait_ack(40, -1, cyc, a_o, r_o, e_o, starts, busy_cyc, stable);
        req_valid = '0;
        checks++;
        if (cyc !== 4 || a_o !== (NREQ'(1) << w) ||
            r_o !== exp_res(op_a[w], op_b[w], req_sub[w])) begin
            errors++;
            $display("FAIL reset_ptr: ack %b at cycle %0d, want %b at 4", a_o, cyc,
                     NREQ'(1) << w);
        end
        ptr_m = (w + 1) % NREQ;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
